// File: rtl/div_iter_pkg.sv
// Shared constants for the iterative divider: aluop codes, FSM state encodings
// and handshake levels used by the execute stage.
package div_iter_pkg;

  localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

endpackage

// File: rtl/div_iter.sv
// Multi-cycle restoring divider (one quotient bit per clock) for DIV/DIVU.
// result_o = {remainder, quotient}; stall_o holds the pipeline until ready_o.
module div_iter
  import div_iter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               annul_i,
  input  logic               signed_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               stall_o
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  function automatic logic [WIDTH-1:0] div_abs(input logic [WIDTH-1:0] v, input logic neg);
    logic [WIDTH-1:0] one;
    one = {{(WIDTH-1){1'b0}}, 1'b1};
    return neg ? (~v + one) : v;
  endfunction

  div_state_e         state_q;
  logic [WIDTH-1:0]   quot_q;
  logic [WIDTH-1:0]   rem_q;
  logic [WIDTH-1:0]   divisor_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               neg_quot_q;
  logic               neg_rem_q;
  logic [2*WIDTH-1:0] fixed_q;

  logic [WIDTH:0]     partial_d;
  logic [WIDTH:0]     diff_d;
  logic               qbit_d;
  logic [WIDTH-1:0]   quot_d;
  logic [WIDTH-1:0]   rem_d;

  // Remainder stays below the divisor, so a WIDTH+1-bit trial subtraction's MSB is its sign.
  always_comb begin
    partial_d = {rem_q, quot_q[WIDTH-1]};
    diff_d    = partial_d - {1'b0, divisor_q};
    qbit_d    = ~diff_d[WIDTH];
    quot_d    = {quot_q[WIDTH-2:0], qbit_d};
    if (qbit_d) begin
      rem_d = diff_d[WIDTH-1:0];
    end else begin
      rem_d = partial_d[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= DivFree;
      quot_q     <= '0;
      rem_q      <= '0;
      divisor_q  <= '0;
      cnt_q      <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      fixed_q    <= '0;
      result_o   <= '0;
      ready_o    <= DivResultNotReady;
    end else begin
      case (state_q)
        DivFree: begin
          ready_o  <= DivResultNotReady;
          result_o <= '0;
          if (start_i == DivStart && !annul_i) begin
            if (opdata2_i == '0) begin
              state_q <= DivByZero;
            end else begin
              state_q    <= DivOn;
              cnt_q      <= '0;
              rem_q      <= '0;
              quot_q     <= div_abs(opdata1_i, signed_i & opdata1_i[WIDTH-1]);
              divisor_q  <= div_abs(opdata2_i, signed_i & opdata2_i[WIDTH-1]);
              neg_quot_q <= signed_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
              neg_rem_q  <= signed_i & opdata1_i[WIDTH-1];
            end
          end
        end
        DivByZero: begin
          fixed_q <= '0;
          state_q <= DivEnd;
        end
        DivOn: begin
          if (annul_i) begin
            state_q <= DivFree;
          end else begin
            quot_q <= quot_d;
            rem_q  <= rem_d;
            cnt_q  <= cnt_q + CNT_ONE;
            // Sign fix is folded into the last iteration so END only presents it.
            if (cnt_q == LAST_CNT) begin
              fixed_q <= {div_abs(rem_d, neg_rem_q), div_abs(quot_d, neg_quot_q)};
              state_q <= DivEnd;
            end
          end
        end
        DivEnd: begin
          if (start_i == DivStart) begin
            result_o <= fixed_q;
            ready_o  <= DivResultReady;
          end else begin
            state_q  <= DivFree;
            result_o <= '0;
            ready_o  <= DivResultNotReady;
          end
        end
        default: begin
          state_q  <= DivFree;
          result_o <= '0;
          ready_o  <= DivResultNotReady;
        end
      endcase
    end
  end

  // Stall from the request cycle until the result is presented.
  always_comb begin
    stall_o = 1'b0;
    case (state_q)
      DivFree:   stall_o = (start_i == DivStart) & ~annul_i;
      DivByZero: stall_o = 1'b1;
      DivOn:     stall_o = 1'b1;
      default:   stall_o = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_div_iter.sv
// Directed bench for div_iter: table of divides on a 32-bit and an 8-bit instance,
// plus hand sequences for hold, annul and asynchronous reset.
module tb_div_iter;

  logic        clk;
  logic        rst;
  logic        annul;
  logic        sgn;
  logic        start32;
  logic        start8;
  logic [31:0] a32, b32;
  logic [7:0]  a8, b8;
  logic [63:0] res32;
  logic [15:0] res8;
  logic        ready32, ready8, stall32, stall8;

  int checks = 0;
  int errors = 0;

  div_iter #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .start_i(start32), .annul_i(annul), .signed_i(sgn),
    .opdata1_i(a32), .opdata2_i(b32), .result_o(res32), .ready_o(ready32), .stall_o(stall32)
  );

  div_iter #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start_i(start8), .annul_i(annul), .signed_i(sgn),
    .opdata1_i(a8), .opdata2_i(b8), .result_o(res8), .ready_o(ready8), .stall_o(stall8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    bit          w8;
    logic        sg;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic sel_ready(input bit w8);
    return w8 ? ready8 : ready32;
  endfunction

  function automatic logic sel_stall(input bit w8);
    return w8 ? stall8 : stall32;
  endfunction

  function automatic logic [63:0] sel_res(input bit w8);
    return w8 ? {48'h0, res8} : res32;
  endfunction

  task automatic set_start(input bit w8, input logic v);
    if (w8) start8 = v;
    else start32 = v;
  endtask

  task automatic wait_ready(input bit w8, input int limit, output bit got, output int lat);
    got = 1'b0;
    lat = -1;
    for (int i = 0; i < limit && !got; i++) begin
      @(posedge clk); #1;
      if (sel_ready(w8)) begin
        got = 1'b1;
        lat = i;
      end
    end
  endtask

  // Called at posedge+1; the next edge is E0.
  task automatic run_div(input vec_t v);
    bit got;
    int lat;
    bit stall_bad;
    if (v.w8) begin
      a8 = v.a[7:0];
      b8 = v.b[7:0];
    end else begin
      a32 = v.a;
      b32 = v.b;
    end
    sgn = v.sg;
    set_start(v.w8, 1'b1);
    #1;
    check({v.nm, " stall_req"}, {63'h0, sel_stall(v.w8)}, 64'h1);
    got = 1'b0;
    lat = -1;
    stall_bad = 1'b0;
    for (int i = 0; i < 64 && !got; i++) begin
      @(posedge clk); #1;
      if (i == 0) begin
        a32 = 32'hDEAD_BEEF;
        b32 = 32'h0000_0003;
        a8  = 8'h5A;
        b8  = 8'h07;
      end
      if (sel_ready(v.w8)) begin
        got = 1'b1;
        lat = i;
      end else if (sel_stall(v.w8) != ((i < v.lat - 1) ? 1'b1 : 1'b0)) begin
        stall_bad = 1'b1;
      end
    end
    check({v.nm, " ready_seen"}, {63'h0, got}, 64'h1);
    check({v.nm, " latency"}, 64'(lat), 64'(v.lat));
    check({v.nm, " result"}, sel_res(v.w8), v.exp);
    check({v.nm, " stall_profile"}, {63'h0, stall_bad}, 64'h0);
    check({v.nm, " stall_ready"}, {63'h0, sel_stall(v.w8)}, 64'h0);
    set_start(v.w8, 1'b0);
    @(posedge clk); #1;
    check({v.nm, " ready_drop"}, {63'h0, sel_ready(v.w8)}, 64'h0);
    check({v.nm, " result_clear"}, sel_res(v.w8), 64'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    bit got;
    int lat;
    vec_t v;

    vecs[0]  = '{"divu_100_7",     1'b0, 1'b0, 32'd100,        32'd7,          64'h00000002_0000000E, 33};
    vecs[1]  = '{"div_m7_2",       1'b0, 1'b1, 32'hFFFFFFF9,   32'h00000002,   64'hFFFFFFFF_FFFFFFFD, 33};
    vecs[2]  = '{"div_7_m2",       1'b0, 1'b1, 32'h00000007,   32'hFFFFFFFE,   64'h00000001_FFFFFFFD, 33};
    vecs[3]  = '{"div_ovf",        1'b0, 1'b1, 32'h80000000,   32'hFFFFFFFF,   64'h00000000_80000000, 33};
    vecs[4]  = '{"divu_max_1",     1'b0, 1'b0, 32'hFFFFFFFF,   32'h00000001,   64'h00000000_FFFFFFFF, 33};
    vecs[5]  = '{"divu_8000_ffff", 1'b0, 1'b0, 32'h80000000,   32'hFFFFFFFF,   64'h80000000_00000000, 33};
    vecs[6]  = '{"div_m100_m7",    1'b0, 1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   64'hFFFFFFFE_0000000E, 33};
    vecs[7]  = '{"divu_by_zero",   1'b0, 1'b0, 32'h00001234,   32'h00000000,   64'h0,                 2};
    vecs[8]  = '{"div_by_zero",    1'b0, 1'b1, 32'h80000000,   32'h00000000,   64'h0,                 2};
    vecs[9]  = '{"w8_div_81_3",    1'b1, 1'b1, 32'h00000081,   32'h00000003,   64'h00000000_0000FFD6, 9};
    vecs[10] = '{"w8_divu_ff_10",  1'b1, 1'b0, 32'h000000FF,   32'h00000010,   64'h00000000_00000F0F, 9};
    vecs[11] = '{"divu_5_7",       1'b0, 1'b0, 32'h00000005,   32'h00000007,   64'h00000005_00000000, 33};

    rst = 1'b1;
    annul = 1'b0;
    sgn = 1'b0;
    start32 = 1'b0;
    start8 = 1'b0;
    a32 = 32'h0;
    b32 = 32'h0;
    a8 = 8'h0;
    b8 = 8'h0;
    #12;
    check("reset ready", {63'h0, ready32}, 64'h0);
    check("reset result", res32, 64'h0);
    check("reset stall", {63'h0, stall32}, 64'h0);
    check("reset result8", {48'h0, res8}, 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    for (int k = 0; k < 12; k++) begin
      run_div(vecs[k]);
    end

    // Divide-by-zero held in END, with an ignored annul pulse.
    a32 = 32'h00001234;
    b32 = 32'h0;
    sgn = 1'b0;
    start32 = 1'b1;
    wait_ready(1'b0, 10, got, lat);
    check("dz_hold latency", 64'(lat), 64'd2);
    for (int i = 0; i < 5; i++) begin
      annul = (i == 2) ? 1'b1 : 1'b0;
      @(posedge clk); #1;
      check("dz_hold ready", {63'h0, ready32}, 64'h1);
      check("dz_hold result", res32, 64'h0);
    end
    annul = 1'b0;
    start32 = 1'b0;
    @(posedge clk); #1;
    check("dz_hold drop", {63'h0, ready32}, 64'h0);

    // Annul mid-ON, then an immediate 9/3.
    a32 = 32'd100;
    b32 = 32'd7;
    start32 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (i == 9) annul = 1'b1;
    end
    @(posedge clk); #1;
    annul = 1'b0;
    start32 = 1'b0;
    #1;
    check("annul idle_stall", {63'h0, stall32}, 64'h0);
    check("annul ready", {63'h0, ready32}, 64'h0);
    v = '{"after_annul_9_3", 1'b0, 1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 33};
    run_div(v);

    // Asynchronous reset between edges while ON.
    a32 = 32'd100;
    b32 = 32'd7;
    start32 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
    end
    #3;
    check("pre_rst stall", {63'h0, stall32}, 64'h1);
    rst = 1'b1;
    start32 = 1'b0;
    #1;
    check("async_rst stall", {63'h0, stall32}, 64'h0);
    check("async_rst ready", {63'h0, ready32}, 64'h0);
    check("async_rst result", res32, 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Asynchronous reset while the 8-bit result is presented.
    a8 = 8'h81;
    b8 = 8'h03;
    sgn = 1'b1;
    start8 = 1'b1;
    wait_ready(1'b1, 20, got, lat);
    check("w8 pre_rst result", {48'h0, res8}, 64'h000000000000FFD6);
    #3;
    rst = 1'b1;
    #1;
    check("w8 async_rst ready", {63'h0, ready8}, 64'h0);
    check("w8 async_rst result", {48'h0, res8}, 64'h0);
    start8 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_iter.md
Name: div_iter

Overview:
Parametrised multi-cycle integer divider for the openmips execute stage. It serves DIV/DIVU, producing quotient (to LO) and remainder (to HI) by restoring shift-subtract at one bit per clock. It holds the pipeline through a stall-request output and accepts an annul so a flushed divide is abandoned. It generalises the single-cycle ALU datapath to a configurable operand width with signed/unsigned mode and a start/ready handshake.

Parameters:
WIDTH, 32, operand width in bits (≥2); result is 2*WIDTH.
CNT_W, clog2(WIDTH+1), iteration counter width (derived localparam, not overridable).

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
start_i  in  1  divide request, held by EX until ready_o seen
annul_i  in  1  cancel current/incoming operation (pipeline flush)
signed_i  in  1  1 = DIV (two's complement), 0 = DIVU
opdata1_i  in  WIDTH  dividend
opdata2_i  in  WIDTH  divisor
result_o  out  2*WIDTH  {remainder, quotient}; upper half to HI, lower half to LO
ready_o  out  1  result_o valid
stall_o  out  1  stall request to pipeline control

Behaviour:
- Reset (async, rst=1): state IDLE, result_o=0, ready_o=0, counter=0, internal dividend/divisor regs=0. Reset mid-operation aborts immediately; no partial result is visible.
- FSM states: IDLE, DIVZERO, ON, END.
- IDLE:
  - start_i=1 & annul_i=0 & opdata2_i==0 → DIVZERO.
  - start_i=1 & annul_i=0 & divisor≠0 → ON. Operands are latched; if signed_i, absolute values are taken and the sign flags are stored. Counter is cleared.
  - Otherwise stay in IDLE; ready_o=0; result_o=0.
- DIVZERO: one cycle, then END with result_o=0 (quotient 0, remainder 0).
- ON:
  - annul_i=1 → IDLE, result discarded, ready_o stays 0.
  - Otherwise perform one iteration: shift the partial remainder left by 1 and bring in the next dividend MSB. Trial-subtract the divisor using a WIDTH+1-bit subtraction. If non-negative, keep the difference and shift 1 into the quotient; else shift 0. Increment the counter.
  - When counter==WIDTH-1 the final iteration completes and the next state is END.
- Entering END: sign fix is applied in the transition cycle.
  - Quotient is negated iff signed_i and operand signs differ.
  - Remainder is negated iff signed_i and dividend negative.
  - Result is registered into result_o; ready_o=1.
- END: holds ready_o=1 and result_o while start_i=1. start_i=0 → IDLE, with ready_o=0 and result_o=0 on the next edge.
- Latency: start_i accepted at edge E0 → ready_o high after edge E(WIDTH+1). Divide-by-zero: ready_o high after edge E2.
- stall_o is combinational: 1 when (IDLE & start_i & ~annul_i) or DIVZERO or ON. It is 0 in END and in IDLE without a request. The pipeline is therefore stalled from the request cycle until ready_o.
- Overflow: signed most-negative ÷ −1 gives quotient = most-negative (wraps), remainder 0, with no exception. Arithmetic is modulo 2^WIDTH.
- annul_i in DIVZERO or END is ignored; the result completes and the handshake ends normally.
- Operand changes on opdata*_i after acceptance have no effect.

Decomposition:
- Shared package (defines file) holds:
  - EXE_DIV_OP and EXE_DIVU_OP aluop codes.
  - DivFree/DivByZero/DivOn/DivEnd 2-bit state encodings.
  - DivResultReady/DivResultNotReady and DivStart/DivStop constants.
- No sub-module required. An optional combinational helper div_abs (conditional two's-complement negate, WIDTH-parametrised) is reused for operand preprocessing and sign fix.

Test Plan:
- WIDTH=32, DIVU 100/7: start at E0 → ready_o after E33; result_o={32'd2, 32'd14}; stall_o high E0..E32, low once ready.
- DIV −7/2 (0xFFFFFFF9 / 0x2) → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. DIV 7/−2 → quotient 0xFFFFFFFD, remainder 0x00000001.
- DIV 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0. DIVU 0xFFFFFFFF/1 → quotient 0xFFFFFFFF, remainder 0.
- Divisor 0 with dividend 0x1234 → ready_o after E2, result_o=0. Hold start_i 5 extra cycles → ready_o stays 1; drop start_i → IDLE, ready_o=0 next cycle.
- annul_i pulsed at E10 of a 100/7 divide → IDLE at E11, ready_o never rises. An immediately following 9/3 request completes with quotient 3, remainder 0 at the correct latency.
- rst asserted asynchronously mid-ON (between edges) → result_o=0, ready_o=0, stall_o=0 without waiting for a clock. Rerun WIDTH=8: DIV 0x81/0x03 → quotient 0xD6, remainder 0xFF; ready after E9.
